// File: rtl/counter_sequencer.sv
// Programmable interval timer: a valid/ready start command loads a terminal count
// and mode, then an n-bit up-counter runs 0..P with pause, abort, tick and done.
module counter_sequencer #(
  parameter int n = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [n-1:0] cmd_period,
  input  logic         cmd_periodic,
  input  logic         pause,
  input  logic         abort,
  output logic [n-1:0] q,
  output logic         tick,
  output logic         done,
  output logic         busy,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t       cur_state;
  logic [n-1:0] period;
  logic         periodic;
  logic         at_terminal;
  logic         accept;

  // Handshake: a command transfers on any edge where cmd_valid & cmd_ready;
  // cmd_ready is high only in IDLE and does not depend on cmd_valid.
  assign cmd_ready   = (cur_state == IDLE);
  assign busy        = (cur_state != IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign state       = cur_state;

  // Terminal count only counts when nothing of higher priority claims the edge.
  assign at_terminal = (cur_state == RUN) && (q == period);
  assign tick        = at_terminal & ~pause & ~abort & ~clear;
  assign done        = tick & ~periodic;

  always_ff @(posedge clock) begin
    if (clear) begin
      cur_state <= IDLE;
      q         <= '0;
      period    <= '0;
      periodic  <= 1'b0;
    end else begin
      case (cur_state)
        IDLE: begin
          q <= '0;
          if (accept) begin
            period    <= cmd_period;
            periodic  <= cmd_periodic;
            cur_state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            q         <= '0;
            cur_state <= IDLE;
          end else if (pause) begin
            cur_state <= PAUSED;
          end else if (q == period) begin
            // Reload before any increment, so an all-ones period never wraps.
            q <= '0;
            if (!periodic) cur_state <= IDLE;
          end else begin
            q <= q + 1'b1;
          end
        end
        PAUSED: begin
          if (abort) begin
            q         <= '0;
            cur_state <= IDLE;
          end else if (!pause) begin
            cur_state <= RUN;
          end
        end
        default: begin
          q         <= '0;
          cur_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: per-cycle vectors of {inputs, expected outputs},
// expected values pushed to a queue on drive and popped when outputs are sampled.
module tb_counter_sequencer;

  localparam int N = 4;
  localparam int W = N + 4;

  logic         clock = 1'b0;
  logic         clear;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_period;
  logic         cmd_periodic;
  logic         pause;
  logic         abort;
  logic [N-1:0] q;
  logic         tick;
  logic         done;
  logic         busy;
  logic [1:0]   state;

  counter_sequencer #(.n(N)) dut (
    .clock        (clock),
    .clear        (clear),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_period   (cmd_period),
    .cmd_periodic (cmd_periodic),
    .pause        (pause),
    .abort        (abort),
    .q            (q),
    .tick         (tick),
    .done         (done),
    .busy         (busy),
    .state        (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         clr;
    logic         cv;
    logic [N-1:0] p;
    logic         per;
    logic         pa;
    logic         ab;
    logic [N-1:0] eq;
    logic         et;
    logic         ed;
    logic         er;
    logic         eb;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           n_applied = 0;
  int           n_fail    = 0;

  function automatic vec_t mk(input logic clr, input logic cv, input logic [N-1:0] p,
                              input logic per, input logic pa, input logic ab,
                              input logic [N-1:0] eq, input logic et, input logic ed,
                              input logic er, input logic eb);
    vec_t v;
    v.clr = clr; v.cv = cv; v.p = p; v.per = per; v.pa = pa; v.ab = ab;
    v.eq = eq; v.et = et; v.ed = ed; v.er = er; v.eb = eb;
    return v;
  endfunction

  // Idle cycle, optionally offering a command.
  function automatic vec_t idl(input logic cv, input logic [N-1:0] p, input logic per);
    return mk(1'b0, cv, p, per, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  // Plain running cycle with quiet inputs.
  function automatic vec_t rn(input logic [N-1:0] eq, input logic et, input logic ed);
    return mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, eq, et, ed, 1'b0, 1'b1);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    clear        = v.clr;
    cmd_valid    = v.cv;
    cmd_period   = v.p;
    cmd_periodic = v.per;
    pause        = v.pa;
    abort        = v.ab;
    exp_q.push_back({v.eq, v.et, v.ed, v.er, v.eb});
    #4;
    got = {q, tick, done, cmd_ready, busy};
    exp = exp_q.pop_front();
    n_applied++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec %0d: got q=%0d tick=%b done=%b ready=%b busy=%b, required q=%0d tick=%b done=%b ready=%b busy=%b",
               idx, got[W-1:4], got[3], got[2], got[1], got[0],
               exp[W-1:4], exp[3], exp[2], exp[1], exp[0]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic add_periodic_run(input int p);
    logic [N-1:0] pv;
    logic [N-1:0] qv;
    pv = p[N-1:0];
    vecs.push_back(idl(1'b1, pv, 1'b1));
    for (int i = 0; i < 2 * (p + 1); i++) begin
      qv = N'(i % (p + 1));
      vecs.push_back(rn(qv, qv == pv, 1'b0));
    end
    vecs.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(idl(1'b0, '0, 1'b0));
  endtask

  initial begin
    clear = 1'b1; cmd_valid = 1'b0; cmd_period = '0; cmd_periodic = 1'b0;
    pause = 1'b0; abort = 1'b0;
    @(posedge clock);
    #1;

    // Reset state, then pause/abort ignored while idle.
    vecs.push_back(idl(1'b0, '0, 1'b0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    // One-shot P=3.
    vecs.push_back(idl(1'b1, 4'd3, 1'b0));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(rn(1, 0, 0));
    vecs.push_back(rn(2, 0, 0));
    vecs.push_back(rn(3, 1, 1));
    vecs.push_back(idl(1'b0, '0, 1'b0));
    // Clear mid-run, periodic P=5.
    vecs.push_back(idl(1'b1, 4'd5, 1'b1));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(rn(1, 0, 0));
    vecs.push_back(rn(2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1));
    vecs.push_back(idl(1'b0, '0, 1'b0));
    vecs.push_back(idl(1'b0, '0, 1'b0));
    // Periodic P=2, abort at terminal count.
    vecs.push_back(idl(1'b1, 4'd2, 1'b1));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(rn(1, 0, 0));
    vecs.push_back(rn(2, 1, 0));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(rn(1, 0, 0));
    vecs.push_back(rn(2, 1, 0));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(rn(1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1));
    vecs.push_back(idl(1'b0, '0, 1'b0));
    // Periodic P=4 with pause, ignored commands and pause at terminal count.
    vecs.push_back(idl(1'b1, 4'd4, 1'b1));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(rn(1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 7, 0, 1, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1));
    vecs.push_back(rn(2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 3, 0, 0, 0, 1));
    vecs.push_back(rn(4, 1, 0));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(rn(1, 0, 0));
    vecs.push_back(rn(2, 0, 0));
    vecs.push_back(rn(3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1));
    vecs.push_back(rn(4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(idl(1'b0, '0, 1'b0));
    // One-shot P=3: command in RUN ignored, abort beats pause and terminal count.
    vecs.push_back(idl(1'b1, 4'd3, 1'b0));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 1, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(rn(2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 1));
    vecs.push_back(idl(1'b0, '0, 1'b0));
    // P=0 periodic and one-shot, then back-to-back command with P=1.
    vecs.push_back(idl(1'b1, 4'd0, 1'b1));
    vecs.push_back(rn(0, 1, 0));
    vecs.push_back(rn(0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(idl(1'b1, 4'd0, 1'b0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(idl(1'b1, 4'd1, 1'b0));
    vecs.push_back(rn(0, 0, 0));
    vecs.push_back(rn(1, 1, 1));
    vecs.push_back(idl(1'b0, '0, 1'b0));
    // All-ones period, then a few random periods.
    add_periodic_run(15);
    for (int k = 0; k < 3; k++) add_periodic_run(int'($urandom_range(0, 15)));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences an n-bit up-counter as a programmable interval timer.
- Accepts a start command through a valid/ready handshake carrying a terminal count and a mode (one-shot or periodic).
- Runs the counter and supports pause/resume and abort.
- Emits a tick pulse at each terminal count and a done pulse when a one-shot finishes.
- Sits between control logic (FSM or register interface) and any logic needing timed events.

Parameters:
- n, 4, counter and period width in bits.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous, active-high reset.
- cmd_valid  in  1  start command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_period  in  n  terminal count P; counter runs 0..P.
- cmd_periodic  in  1  1 = auto-restart after terminal count, 0 = one-shot.
- pause  in  1  level; hold counter while high.
- abort  in  1  cancel the current run.
- q  out  n  current count value.
- tick  out  1  one-cycle pulse at terminal count.
- done  out  1  one-cycle pulse when a one-shot completes.
- busy  out  1  high in RUN or PAUSED.

Behaviour:
- **States:** IDLE, RUN, PAUSED. State, q, the latched period and the latched mode are registers. cmd_ready, busy, tick and done are decoded combinationally from registers and inputs.
- **Reset:** clear sampled high at a posedge gives:
  - state IDLE, q 0, latched period 0, latched mode 0;
  - hence cmd_ready 1, busy 0, tick 0, done 0.
  - Reset mid-run discards the run with no tick or done.
- **Priority per edge:** clear > abort > pause > terminal count > increment.
- **IDLE:**
  - q held at 0.
  - A handshake (cmd_valid & cmd_ready) at edge k latches cmd_period and cmd_periodic and moves to RUN. q stays 0.
  - abort and pause are ignored in IDLE.
- **RUN, increment:** when not at terminal count, q <= q + 1 on each edge with pause=0 and abort=0.
- **RUN, terminal count (q == P, pause=0, abort=0):**
  - tick = 1 in that cycle.
  - Periodic: q <= 0 and stay in RUN. Tick interval is P+1 cycles.
  - One-shot: done = 1 in the same cycle, q <= 0, go to IDLE. cmd_ready is 1 in the next cycle.
  - First tick occurs P cycles after the first RUN cycle (the RUN cycle with q=0).
- **RUN, pause=1:** go to PAUSED and hold q. tick is suppressed even if q == P.
- **PAUSED:**
  - q held, tick = 0.
  - pause=0 returns to RUN on the next edge; counting resumes from the held q.
- **abort (RUN or PAUSED):** next edge goes to IDLE with q <= 0. tick and done are suppressed in the abort cycle, even if q == P.
- **Commands while busy:** cmd_valid in RUN or PAUSED is not accepted (cmd_ready = 0) and has no effect. The latched period and mode never change mid-run.
- **P = 0:**
  - Periodic: tick every RUN cycle, q stays 0.
  - One-shot: tick and done in the first RUN cycle.
- **P = 2^n - 1:** q reaches the all-ones value, then reloads to 0. No natural overflow path exists, because the terminal-count check precedes the increment.
- **Arithmetic:** all arithmetic is n bits unsigned. q never exceeds the latched P.

Test Plan:
1. **Reset mid-run:** start periodic P=5 and wait until q=3, then clear=1 for one edge → q=0, busy=0, cmd_ready=1, no tick; clear=0 → q stays 0.
2. **One-shot:** P=3, handshake at edge k → q sequence 0,1,2,3 over cycles k+1..k+4. tick=1 and done=1 only at q=3. Next cycle: state IDLE, q=0, cmd_ready=1, busy=0.
3. **Periodic:** P=2 → q sequence 0,1,2,0,1,2,0; tick exactly at each q=2, spaced 3 cycles apart; done never asserts. With n=4, P=15 → tick every 16 cycles and q reloads 15→0.
4. **Pause with terminal-count collision:**
   - Periodic P=4, pause=1 at q=2 for 4 cycles → q holds 2, tick=0.
   - Release → q=3, then q=4 with tick.
   - Pause raised when q=4 → no tick; resume → tick on the first cycle back in RUN.
5. **Abort precedence:** one-shot P=3, pause and abort both 1 at q=3 → next cycle IDLE, q=0, no tick, no done. cmd_valid asserted during RUN is not accepted (cmd_ready=0).
6. **P=0 and back-to-back commands:**
   - Periodic P=0 → tick every cycle, q=0.
   - One-shot P=0 → single tick and done, then IDLE.
   - cmd_valid held high → a new command is accepted in the cycle after done, with new P=1 observed.
